aes_inv_cipher_stream: RTL

Round-iterative AES-128 inverse cipher with valid/ready handshakes on both sides. It is the receive-side counterpart of the encrypt path: it takes a 128-bit ciphertext block plus the expanded key schedule and returns the plaintext. It executes one inverse round per clock and can accept a new block on the same edge its previous result is consumed. It replaces the free-running count-driven decrypt enable with a proper accept/complete protocol.

---
 rtl/aes_pkg.sv | 55 +++++
 rtl/aes_inv_round.sv | 42 ++++
 rtl/aes_inv_cipher_stream.sv | 83 ++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 inverse cipher: sizes, FSM state
// constants, round-key slicing and the GF(2^8) helpers used by the datapath.
package aes_pkg;

  localparam int Nb      = 4;
  localparam int NK      = 4;
  localparam int NR      = 10;
  localparam int BLOCK_W = 128;
  localparam int KEYS_W  = (NR + 1) * BLOCK_W;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ROUNDS = 2'd1;
  localparam logic [1:0] FINAL  = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  // Round key i lives in the slice counted from the MSB end (key 0 first).
  function automatic logic [BLOCK_W-1:0] key_at(input logic [KEYS_W-1:0] keys,
                                                 input int i);
    return keys[(NR - i) * BLOCK_W +: BLOCK_W];
  endfunction

  // Carry-less multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = gf_mul(x, x);
    acc = sq;
    for (int k = 0; k < 6; k++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  // Inverse S-box: undo the affine map, then take the field inverse.
  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    logic [7:0] b;
    b = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes,
// AddRoundKey and, unless is_final, InvMixColumns. Byte 0 is [127:120],
// bytes are column-major (byte 4c+r is row r of column c).
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] state_in,
  input  logic [BLOCK_W-1:0] round_key,
  input  logic               is_final,
  output logic [BLOCK_W-1:0] state_out
);

  // Column by column: gather shifted bytes, substitute, add key, then mix.
  always_comb begin
    logic [3:0][7:0] col;
    logic [3:0][7:0] mixed;
    int              sel;
    state_out = '0;
    col       = '0;
    mixed     = '0;
    sel       = 0;
    for (int c = 0; c < Nb; c++) begin
      for (int r = 0; r < 4; r++) begin
        sel    = ((c - r + 4) % 4) * 4 + r;
        col[r] = inv_sbox(state_in[127 - 8 * sel -: 8])
                 ^ round_key[127 - 8 * (4 * c + r) -: 8];
      end
      for (int r = 0; r < 4; r++) begin
        if (is_final) begin
          mixed[r] = col[r];
        end else begin
          mixed[r] = gf_mul(col[r], 8'h0e)
                   ^ gf_mul(col[(r + 1) % 4], 8'h0b)
                   ^ gf_mul(col[(r + 2) % 4], 8'h0d)
                   ^ gf_mul(col[(r + 3) % 4], 8'h09);
        end
        state_out[127 - 8 * (4 * c + r) -: 8] = mixed[r];
      end
    end
  end

endmodule

// File: rtl/aes_inv_cipher_stream.sv
// Round-iterative AES-128 decryptor with valid/ready on both sides. One
// inverse round per clock; a new block can be taken on the same edge the
// previous plaintext is handed off.
module aes_inv_cipher_stream
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [127:0]             in_cipher,
  input  logic [(Nr+1)*Nk*32-1:0]  round_keys,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [127:0]             out_plain,
  output logic                     busy,
  output logic [3:0]               round_idx
);

  logic [1:0]          state;
  logic [3:0]          cnt;
  logic [BLOCK_W-1:0]  st_reg;
  logic [KEYS_W-1:0]   keys_reg;
  logic [BLOCK_W-1:0]  round_out;
  logic                accept;

  // The only entry points for a new block are IDLE and a HOLD handoff.
  assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (state == ROUNDS) || (state == FINAL);
  assign round_idx = busy ? cnt : 4'd0;

  aes_inv_round u_round (
    .state_in  (st_reg),
    .round_key (key_at(keys_reg, int'(cnt))),
    .is_final  (state == FINAL),
    .state_out (round_out)
  );

  // FSM, round counter and datapath registers; the key schedule is copied
  // at accept so later changes on round_keys cannot disturb a block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      st_reg    <= '0;
      keys_reg  <= '0;
      out_plain <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      st_reg    <= in_cipher ^ key_at(round_keys, NR);
      keys_reg  <= round_keys;
      cnt       <= 4'(NR - 1);
      out_valid <= 1'b0;
      state     <= ROUNDS;
    end else begin
      case (state)
        ROUNDS: begin
          st_reg <= round_out;
          cnt    <= cnt - 4'd1;
          if (cnt == 4'd1) state <= FINAL;
        end
        FINAL: begin
          st_reg    <= round_out;
          out_plain <= round_out;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
